decoder_scan: RTL and testbench

Registered 4-to-16 one-hot decoder with enable and a self-timed scan sequencer; it is the inverse of the team's 16-to-4 binary encoder. A 4-bit index is loaded and held as a one-hot word, or the block steps the active bit through all 16 positions with a programmable dwell time. Its output can be looped back into the encoder, so the encoder output must equal `index_out` at every step.

---
 rtl/decoder_scan.sv | 130 +++++++++++++
 tb/tb_decoder_scan.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// decoder_scan: registered 4-to-16 one-hot decoder with a self-timed scan
// sequencer. A loaded index is held as a one-hot word, or the active bit is
// stepped through all 16 positions with DWELL cycles per position.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous active-high reset
//   enable       block enable; low forces outputs to zero and aborts a scan
//   load         strobe: capture binary_in and hold its one-hot decode
//   binary_in    index to decode (sampled only when load is accepted)
//   scan_start   start (or restart) a scan from index 0
//   scan_stop    abort a running scan
//   decoder_out  registered one-hot word, or all zeros
//   index_out    binary index of the active bit, 0 when decoder_out is zero
//   busy         high while scanning
//   done         one-cycle pulse when a scan completes normally
//
// State table
//   IDLE | outputs zero, waiting for load or scan_start
//   HOLD | holding the one-hot decode of the last loaded index
//   SCAN | stepping the active bit 0..15, DWELL cycles per position
module decoder_scan #(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [3:0]  binary_in,
  input  logic        scan_start,
  input  logic        scan_stop,
  output logic [15:0] decoder_out,
  output logic [3:0]  index_out,
  output logic        busy,
  output logic        done
);

  localparam int CW = ($clog2(DWELL + 1) < 1) ? 1 : $clog2(DWELL + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t         state_q;
  logic [15:0]    dec_q;
  logic [3:0]     idx_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dec_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!enable) begin
        state_q <= IDLE;
        dec_q   <= '0;
        idx_q   <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, HOLD: begin
            if (scan_start) begin
              state_q <= SCAN;
              dec_q   <= 16'h0001;
              idx_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end else if (load) begin
              state_q <= HOLD;
              dec_q   <= 16'h0001 << binary_in;
              idx_q   <= binary_in;
            end
          end
          SCAN: begin
            if (scan_start) begin
              dec_q <= 16'h0001;
              idx_q <= '0;
              cnt_q <= '0;
            end else if (scan_stop) begin
              state_q <= IDLE;
              dec_q   <= '0;
              idx_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end else if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              // Exit happens at index 15, so the index never wraps.
              if (idx_q == 4'd15) begin
                state_q <= IDLE;
                dec_q   <= '0;
                idx_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                dec_q <= dec_q << 1;
                idx_q <= idx_q + 4'd1;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            dec_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign decoder_out = dec_q;
  assign index_out   = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_decoder_scan.sv
module tb_decoder_scan;

  logic        clk;
  // instance a: DWELL=4
  logic        reset, enable, load, scan_start, scan_stop;
  logic [3:0]  binary_in;
  logic [15:0] decoder_out;
  logic [3:0]  index_out;
  logic        busy, done;
  // instance b: DWELL=1
  logic        reset_b1, enable_b1, load_b1, scan_start_b1, scan_stop_b1;
  logic [3:0]  binary_in_b1;
  logic [15:0] decoder_out_b1;
  logic [3:0]  index_out_b1;
  logic        busy_b1, done_b1;

  int tests;
  int failed;
  int busy_cnt;

  decoder_scan #(.DWELL(4)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .binary_in(binary_in), .scan_start(scan_start), .scan_stop(scan_stop),
    .decoder_out(decoder_out), .index_out(index_out), .busy(busy), .done(done)
  );

  decoder_scan #(.DWELL(1)) u_dut1 (
    .clk(clk), .reset(reset_b1), .enable(enable_b1), .load(load_b1),
    .binary_in(binary_in_b1), .scan_start(scan_start_b1), .scan_stop(scan_stop_b1),
    .decoder_out(decoder_out_b1), .index_out(index_out_b1), .busy(busy_b1), .done(done_b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 16-to-4 encoder (loopback model).
  function automatic logic [3:0] enc(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [15:0] d, input logic [3:0] ix,
                       input logic b, input logic dn);
    chk({tag, ".dec"}, 32'(decoder_out), 32'(d));
    chk({tag, ".idx"}, 32'(index_out), 32'(ix));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  task automatic chk_b(input string tag, input logic [15:0] d, input logic [3:0] ix,
                       input logic b, input logic dn);
    chk({tag, ".dec"}, 32'(decoder_out_b1), 32'(d));
    chk({tag, ".idx"}, 32'(index_out_b1), 32'(ix));
    chk({tag, ".busy"}, 32'(busy_b1), 32'(b));
    chk({tag, ".done"}, 32'(done_b1), 32'(dn));
  endtask

  initial begin
    tests = 0; failed = 0;
    reset = 1; enable = 0; load = 0; scan_start = 0; scan_stop = 0; binary_in = 0;
    reset_b1 = 1; enable_b1 = 0; load_b1 = 0; scan_start_b1 = 0; scan_stop_b1 = 0;
    binary_in_b1 = 0;

    // reset and enable gating
    tick(); tick();
    chk_a("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    reset = 0;
    load = 1; binary_in = 4'd5;
    tick();
    load = 0;
    chk_a("gated_load", 16'h0000, 4'd0, 1'b0, 1'b0);
    tick();
    chk_a("gated_load2", 16'h0000, 4'd0, 1'b0, 1'b0);

    // all loads
    enable = 1;
    for (int i = 0; i < 16; i++) begin
      load = 1; binary_in = 4'(i);
      tick();
      chk($sformatf("load%0d.dec", i), 32'(decoder_out), 32'(16'h0001 << i));
      chk($sformatf("load%0d.idx", i), 32'(index_out), 32'(i));
      chk($sformatf("load%0d.enc", i), 32'(enc(decoder_out)), 32'(i));
    end
    load = 0;
    tick();
    chk("hold15.dec", 32'(decoder_out), 32'h8000);

    // full scan, DWELL=4
    scan_start = 1;
    tick();
    scan_start = 0;
    busy_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("scan%0d_%0d.dec", k, d), 32'(decoder_out), 32'(16'h0001 << k));
        chk($sformatf("scan%0d_%0d.enc", k, d), 32'(enc(decoder_out)), 32'(index_out));
        chk($sformatf("scan%0d_%0d.idx", k, d), 32'(index_out), 32'(k));
        chk($sformatf("scan%0d_%0d.done", k, d), 32'(done), 32'd0);
        if (busy) busy_cnt++;
        tick();
      end
    end
    chk("scan.busy_cycles", 32'(busy_cnt), 32'd64);
    chk_a("scan_end", 16'h0000, 4'd0, 1'b0, 1'b1);
    tick();
    chk_a("scan_end+1", 16'h0000, 4'd0, 1'b0, 1'b0);

    // abort by scan_stop at index 7
    scan_start = 1;
    tick();
    scan_start = 0;
    for (int i = 0; i < 28; i++) tick();
    chk_a("at7", 16'h0080, 4'd7, 1'b1, 1'b0);
    scan_stop = 1;
    tick();
    scan_stop = 0;
    chk_a("stop", 16'h0000, 4'd0, 1'b0, 1'b0);
    tick();
    chk_a("stop+1", 16'h0000, 4'd0, 1'b0, 1'b0);

    // abort by enable drop at index 3
    scan_start = 1;
    tick();
    scan_start = 0;
    for (int i = 0; i < 12; i++) tick();
    chk_a("at3", 16'h0008, 4'd3, 1'b1, 1'b0);
    enable = 0;
    tick();
    chk_a("disable", 16'h0000, 4'd0, 1'b0, 1'b0);
    enable = 1;
    tick();
    chk_a("disable+1", 16'h0000, 4'd0, 1'b0, 1'b0);

    // load together with scan_start in IDLE: scan wins
    load = 1; binary_in = 4'd9; scan_start = 1;
    tick();
    load = 0; scan_start = 0;
    chk_a("ld_and_start", 16'h0001, 4'd0, 1'b1, 1'b0);
    tick(); tick();
    load = 1; binary_in = 4'd9;
    tick();
    load = 0;
    chk_a("load_in_scan", 16'h0001, 4'd0, 1'b1, 1'b0);
    tick();
    chk_a("load_in_scan+1", 16'h0002, 4'd1, 1'b1, 1'b0);
    scan_stop = 1;
    tick();
    scan_stop = 0;
    chk_a("stop2", 16'h0000, 4'd0, 1'b0, 1'b0);

    // DWELL=1: mid-scan reset and restart
    reset_b1 = 0; enable_b1 = 1;
    tick();
    chk_b("d1.idle", 16'h0000, 4'd0, 1'b0, 1'b0);
    scan_start_b1 = 1;
    tick();
    scan_start_b1 = 0;
    chk_b("d1.start", 16'h0001, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk_b("d1.at10", 16'h0400, 4'd10, 1'b1, 1'b0);
    reset_b1 = 1;
    tick();
    reset_b1 = 0;
    chk_b("d1.reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    tick();
    chk_b("d1.reset+1", 16'h0000, 4'd0, 1'b0, 1'b0);
    scan_start_b1 = 1;
    tick();
    scan_start_b1 = 0;
    for (int i = 0; i < 12; i++) tick();
    chk_b("d1.at12", 16'h1000, 4'd12, 1'b1, 1'b0);
    scan_start_b1 = 1;
    tick();
    scan_start_b1 = 0;
    chk_b("d1.restart", 16'h0001, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk_b("d1.at15", 16'h8000, 4'd15, 1'b1, 1'b0);
    tick();
    chk_b("d1.end", 16'h0000, 4'd0, 1'b0, 1'b1);
    tick();
    chk_b("d1.end+1", 16'h0000, 4'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
